// File: rtl/conv1_stream_scheduler.sv
// rtl/conv1_stream_scheduler.sv - first conv layer scheduler: per output channel, streams weights then a zero-padded feature frame
module conv1_stream_scheduler #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int QUAN_BITS  = 8,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_CHNNLS = 64,
  parameter int W_WORDS    = 6,
  parameter int FRAM_LAT   = 2,
  parameter int WRAM_LAT   = 1
) (
  input  logic                                  s_clk,
  input  logic                                  s_rst,
  input  logic                                  i_start,
  input  logic                                  network_cal_done,
  output logic                                  o_busy,
  output logic                                  o_layer_done,
  output logic [$clog2(OUT_CHNNLS)-1:0]         o_chnnl_idx,
  output logic                                  o_fram_rd,
  output logic [$clog2(IMG_W*IMG_H)-1:0]        o_fram_addr,
  input  logic [3*QUAN_BITS-1:0]                i_fram_data,
  output logic                                  o_wram_rd,
  output logic [$clog2(OUT_CHNNLS*W_WORDS)-1:0] o_wram_addr,
  input  logic [DATA_WIDTH-1:0]                 i_wram_data,
  output logic [DATA_WIDTH-1:0]                 o_weight,
  output logic                                  o_weight_valid,
  input  logic                                  i_weight_ready,
  output logic [QUAN_BITS-1:0]                  o_feature_ch0,
  output logic [QUAN_BITS-1:0]                  o_feature_ch1,
  output logic [QUAN_BITS-1:0]                  o_feature_ch2,
  output logic                                  o_f_data_valid,
  input  logic                                  i_data_ready,
  input  logic                                  i_load_d_once_done
);

  localparam int CW     = $clog2(OUT_CHNNLS);
  localparam int FAW    = $clog2(IMG_W*IMG_H);
  localparam int XW     = $clog2(IMG_W+2);
  localparam int YW     = $clog2(IMG_H+2);
  localparam int NPIX   = (IMG_W+2)*(IMG_H+2);
  localparam int PW     = $clog2(NPIX+1);
  localparam int KW     = $clog2(W_WORDS+1);
  localparam int FDEPTH = FRAM_LAT+2;
  localparam int PTRW   = $clog2(FDEPTH);
  localparam int OCW    = $clog2(FDEPTH+1);
  localparam int FW     = 3*QUAN_BITS;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_F, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic [KW-1:0]       w_k;
  logic [WRAM_LAT:1]   w_pipe;
  logic                f_iss, f_pad0;
  logic [FRAM_LAT:1]   f_pipe_v, f_pipe_pad;
  logic [XW-1:0]       f_x;
  logic [YW-1:0]       f_y;
  logic                f_iss_done;
  logic [FAW-1:0]      f_next_addr;
  logic [PW-1:0]       out_cnt;
  logic [OCW-1:0]      occ, inflight;
  logic [PTRW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]       fifo_mem [FDEPTH];

  logic w_xfer, f_pop, f_push, border, can_issue;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FDEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_xfer = o_weight_valid && i_weight_ready;
  assign f_pop  = o_f_data_valid && i_data_ready;
  assign f_push = f_pipe_v[FRAM_LAT];
  assign border = (f_x == '0) || (f_x == XW'(IMG_W+1)) || (f_y == '0) || (f_y == YW'(IMG_H+1));
  // credits cover both buffered pixels and pixels still in the RAM/pad delay line
  assign can_issue = (state == S_LOAD_F) && !f_iss_done &&
                     (({1'b0, occ} + {1'b0, inflight}) < (OCW+1)'(FDEPTH));

  assign o_f_data_valid = (occ != '0);
  assign {o_feature_ch2, o_feature_ch1, o_feature_ch0} = fifo_mem[rd_ptr];

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      state <= S_IDLE;
      o_busy <= 1'b0; o_layer_done <= 1'b0; o_chnnl_idx <= '0;
      o_fram_rd <= 1'b0; o_fram_addr <= '0; o_wram_rd <= 1'b0; o_wram_addr <= '0;
      o_weight <= '0; o_weight_valid <= 1'b0;
      w_k <= '0; w_pipe <= '0;
      f_iss <= 1'b0; f_pad0 <= 1'b0; f_pipe_v <= '0; f_pipe_pad <= '0;
      f_x <= '0; f_y <= '0; f_iss_done <= 1'b0; f_next_addr <= '0; out_cnt <= '0;
      occ <= '0; inflight <= '0; wr_ptr <= '0; rd_ptr <= '0;
      for (int i = 0; i < FDEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      o_layer_done <= 1'b0;
      o_wram_rd    <= 1'b0;
      o_fram_rd    <= 1'b0;
      f_iss        <= 1'b0;
      f_pad0       <= 1'b0;

      w_pipe[1] <= o_wram_rd;
      for (int i = 2; i <= WRAM_LAT; i++) w_pipe[i] <= w_pipe[i-1];
      f_pipe_v[1]   <= f_iss;
      f_pipe_pad[1] <= f_pad0;
      for (int i = 2; i <= FRAM_LAT; i++) begin
        f_pipe_v[i]   <= f_pipe_v[i-1];
        f_pipe_pad[i] <= f_pipe_pad[i-1];
      end

      if (w_pipe[WRAM_LAT]) begin
        o_weight       <= i_wram_data;
        o_weight_valid <= 1'b1;
      end
      if (w_xfer) o_weight_valid <= 1'b0;

      if (f_push) begin
        fifo_mem[wr_ptr] <= f_pipe_pad[FRAM_LAT] ? '0 : i_fram_data;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (f_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (f_push && !f_pop)      occ <= occ + 1'b1;
      else if (!f_push && f_pop) occ <= occ - 1'b1;
      if (can_issue && !f_push)      inflight <= inflight + 1'b1;
      else if (!can_issue && f_push) inflight <= inflight - 1'b1;

      case (state)
        S_IDLE: if (i_start) begin
          state <= S_LOAD_W; o_busy <= 1'b1; o_chnnl_idx <= '0;
          w_k <= '0; o_wram_rd <= 1'b1; o_wram_addr <= '0;
        end
        S_LOAD_W: if (w_xfer) begin
          if (w_k == KW'(W_WORDS-1)) begin
            state <= S_LOAD_F;
            f_x <= '0; f_y <= '0; f_iss_done <= 1'b0; f_next_addr <= '0; out_cnt <= '0;
          end else begin
            w_k <= w_k + 1'b1; o_wram_rd <= 1'b1; o_wram_addr <= o_wram_addr + 1'b1;
          end
        end
        S_LOAD_F: begin
          if (can_issue) begin
            f_iss  <= 1'b1;
            f_pad0 <= border;
            // the stored image is unpadded, so interior pixels read consecutive addresses
            if (!border) begin
              o_fram_rd   <= 1'b1;
              o_fram_addr <= f_next_addr;
              f_next_addr <= f_next_addr + 1'b1;
            end
            if (f_x == XW'(IMG_W+1)) begin
              f_x <= '0;
              if (f_y == YW'(IMG_H+1)) f_iss_done <= 1'b1;
              else                     f_y <= f_y + 1'b1;
            end else begin
              f_x <= f_x + 1'b1;
            end
          end
          if (f_pop) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == PW'(NPIX-1)) state <= S_WAIT;
          end
        end
        S_WAIT: if (i_load_d_once_done) begin
          if (o_chnnl_idx == CW'(OUT_CHNNLS-1)) begin
            state <= S_DONE; o_layer_done <= 1'b1;
          end else begin
            state <= S_LOAD_W; o_chnnl_idx <= o_chnnl_idx + 1'b1;
            w_k <= '0; o_wram_rd <= 1'b1; o_wram_addr <= o_wram_addr + 1'b1;
          end
        end
        S_DONE: if (network_cal_done) begin
          state <= S_IDLE; o_busy <= 1'b0; o_chnnl_idx <= '0; o_wram_addr <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_stream_scheduler.sv
// tb/tb_conv1_stream_scheduler.sv - self-checking bench for conv1_stream_scheduler
module tb_conv1_stream_scheduler;
  localparam int IMG_W = 4, IMG_H = 4, QB = 8, DW = 64, OC = 2, WW = 6, FL = 4, WL = 2;
  localparam int NPIX = (IMG_W+2)*(IMG_H+2);

  logic s_clk = 1'b0, s_rst = 1'b0;
  logic i_start = 1'b0, network_cal_done = 1'b0, i_load_d_once_done = 1'b0;
  logic i_weight_ready = 1'b1, i_data_ready = 1'b1;
  logic o_busy, o_layer_done, o_fram_rd, o_wram_rd, o_weight_valid, o_f_data_valid;
  logic [0:0] o_chnnl_idx;
  logic [3:0] o_fram_addr, o_wram_addr;
  logic [3*QB-1:0] i_fram_data;
  logic [DW-1:0] i_wram_data, o_weight;
  logic [QB-1:0] o_feature_ch0, o_feature_ch1, o_feature_ch2;

  always #5 s_clk = ~s_clk;

  conv1_stream_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .QUAN_BITS(QB), .DATA_WIDTH(DW),
    .OUT_CHNNLS(OC), .W_WORDS(WW), .FRAM_LAT(FL), .WRAM_LAT(WL)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start), .network_cal_done(network_cal_done),
    .o_busy(o_busy), .o_layer_done(o_layer_done), .o_chnnl_idx(o_chnnl_idx),
    .o_fram_rd(o_fram_rd), .o_fram_addr(o_fram_addr), .i_fram_data(i_fram_data),
    .o_wram_rd(o_wram_rd), .o_wram_addr(o_wram_addr), .i_wram_data(i_wram_data),
    .o_weight(o_weight), .o_weight_valid(o_weight_valid), .i_weight_ready(i_weight_ready),
    .o_feature_ch0(o_feature_ch0), .o_feature_ch1(o_feature_ch1), .o_feature_ch2(o_feature_ch2),
    .o_f_data_valid(o_f_data_valid), .i_data_ready(i_data_ready),
    .i_load_d_once_done(i_load_d_once_done));

  // RAM models: rd qualifies the address, data appears LAT cycles later, junk otherwise
  logic [23:0] fmem [16];
  logic [63:0] wmem [16];
  logic [23:0] fpipe [FL];
  logic [63:0] wpipe [WL];
  always @(posedge s_clk) begin
    fpipe[0] <= o_fram_rd ? fmem[o_fram_addr] : 24'($urandom);
    for (int i = 1; i < FL; i++) fpipe[i] <= fpipe[i-1];
    wpipe[0] <= o_wram_rd ? wmem[o_wram_addr] : {$urandom, $urandom};
    for (int i = 1; i < WL; i++) wpipe[i] <= wpipe[i-1];
  end
  assign i_fram_data = fpipe[FL-1];
  assign i_wram_data = wpipe[WL-1];

  int checks = 0, errors = 0;
  logic [23:0] gold [$];
  logic [23:0] got_f [$];
  logic [63:0] got_w [$];
  int got_fch [$], got_wch [$];
  int stab_err, rd_idle_err, done_cnt, wrd_cnt, frd_cnt, stall_rd, stall_seen;
  bit in_stall = 0;
  logic pw_v = 0, pw_r = 0, pf_v = 0, pf_r = 0;
  logic [63:0] pw_d;
  logic [23:0] pf_d;

  always @(negedge s_clk) begin
    if (s_rst) begin
      if (pw_v && !pw_r && (!o_weight_valid || o_weight !== pw_d)) stab_err++;
      if (pf_v && !pf_r && (!o_f_data_valid || {o_feature_ch2, o_feature_ch1, o_feature_ch0} !== pf_d)) stab_err++;
      if (o_weight_valid && i_weight_ready) begin
        got_w.push_back(o_weight); got_wch.push_back(int'(o_chnnl_idx));
      end
      if (o_f_data_valid && i_data_ready) begin
        got_f.push_back({o_feature_ch2, o_feature_ch1, o_feature_ch0}); got_fch.push_back(int'(o_chnnl_idx));
      end
      if (!o_busy && (o_fram_rd || o_wram_rd)) rd_idle_err++;
      if (o_layer_done) done_cnt++;
      if (o_wram_rd) wrd_cnt++;
      if (o_fram_rd) frd_cnt++;
      if (in_stall) stall_seen++;
      if (in_stall && o_wram_rd) stall_rd++;
      pw_v = o_weight_valid; pw_r = i_weight_ready; pw_d = o_weight;
      pf_v = o_f_data_valid; pf_r = i_data_ready; pf_d = {o_feature_ch2, o_feature_ch1, o_feature_ch0};
    end else begin
      pw_v = 0; pf_v = 0;
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) begin
      fmem[i] = 24'($urandom) | 24'h1;
      wmem[i] = {$urandom, $urandom};
    end
    gold.delete();
    for (int y = 0; y < IMG_H+2; y++)
      for (int x = 0; x < IMG_W+2; x++)
        if (x == 0 || x == IMG_W+1 || y == 0 || y == IMG_H+1) gold.push_back(24'h0);
        else gold.push_back(fmem[(y-1)*IMG_W + (x-1)]);
  endtask

  task automatic clear_mon();
    got_f.delete(); got_w.delete(); got_fch.delete(); got_wch.delete();
    stab_err = 0; rd_idle_err = 0; done_cnt = 0; wrd_cnt = 0; frd_cnt = 0; stall_rd = 0; stall_seen = 0;
  endtask

  // expected stream: weights in address order chnnl*W_WORDS+k, then the padded raster per channel
  function automatic int seq_mismatch();
    int n = 0;
    for (int i = 0; i < got_w.size(); i++)
      if (i >= OC*WW || got_w[i] !== wmem[i] || got_wch[i] != i/WW) n++;
    for (int i = 0; i < got_f.size(); i++)
      if (i >= OC*NPIX || got_f[i] !== gold[i%NPIX] || got_fch[i] != i/NPIX) n++;
    return n;
  endfunction

  task automatic run_layer(input int rmode, input bit stall, input bit extra_once,
                           input bit extra_start, output bit timeout);
    int ch_done = 0, wait_n = 0, stall_n = 0;
    bit once_sent = 0, start_sent = 0;
    timeout = 1;
    @(posedge s_clk); #1 i_start = 1;
    @(posedge s_clk); #1 i_start = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (done_cnt > 0) begin timeout = 0; break; end
      i_weight_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      i_data_ready   = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_stall = 0;
      if (stall && got_w.size() == 3 && stall_n < 10) begin
        i_weight_ready = 0;
        if (o_weight_valid) begin in_stall = 1; stall_n++; end
      end
      i_load_d_once_done = 0;
      i_start = 0;
      if (extra_start && !start_sent && got_w.size() == 2) begin i_start = 1; start_sent = 1; end
      if (extra_once && !once_sent && got_f.size() == 10) begin i_load_d_once_done = 1; once_sent = 1; end
      if (got_f.size() == NPIX*(ch_done+1)) begin
        if (wait_n == 3) begin i_load_d_once_done = 1; ch_done++; wait_n = 0; end
        else wait_n++;
      end
      @(posedge s_clk); #1;
    end
    i_load_d_once_done = 0; i_start = 0; in_stall = 0; i_weight_ready = 1; i_data_ready = 1;
  endtask

  task automatic finish_layer();
    @(posedge s_clk); #1 network_cal_done = 1;
    @(posedge s_clk); #1 network_cal_done = 0;
  endtask

  task automatic test_reset();
    s_rst = 0;
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    checks++;
    if ({o_busy, o_layer_done, o_fram_rd, o_wram_rd, o_weight_valid, o_f_data_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {o_busy, o_layer_done, o_fram_rd, o_wram_rd, o_weight_valid, o_f_data_valid});
    end
    checks++;
    if ({o_chnnl_idx, o_fram_addr, o_wram_addr, o_weight, o_feature_ch2, o_feature_ch1, o_feature_ch0} !== '0) begin
      errors++; $display("FAIL reset_data: nonzero data outputs, weight %h expected 0", o_weight);
    end
    @(posedge s_clk); #1 s_rst = 1;
    fill_mem(); clear_mon();
    @(posedge s_clk); #1 i_start = 1;
    @(posedge s_clk); #1 i_start = 0;
    for (int c = 0; c < 2000 && got_f.size() < 5; c++) @(posedge s_clk);
    checks++;
    if (got_f.size() < 5) begin errors++; $display("FAIL reset_reach_f: got %0d pixels expected >=5", got_f.size()); end
    #1 s_rst = 0;
    @(posedge s_clk); @(negedge s_clk);
    checks++;
    if ({o_busy, o_fram_rd, o_wram_rd, o_weight_valid, o_f_data_valid, o_chnnl_idx} !== 6'b0) begin
      errors++; $display("FAIL reset_abort: got %b expected 000000", {o_busy, o_fram_rd, o_wram_rd, o_weight_valid, o_f_data_valid, o_chnnl_idx});
    end
    repeat (2) @(posedge s_clk);
    #1 s_rst = 1;
    clear_mon();
    repeat (20) @(posedge s_clk);
    @(negedge s_clk);
    checks++;
    if (wrd_cnt + frd_cnt != 0 || o_busy !== 1'b0 || o_f_data_valid !== 1'b0 || got_f.size() != 0) begin
      errors++; $display("FAIL reset_quiet: rd %0d busy %b pixels %0d expected 0 0 0", wrd_cnt + frd_cnt, o_busy, got_f.size());
    end
  endtask

  task automatic test_basic();
    bit to; int zeros = 0;
    fill_mem(); clear_mon();
    run_layer(0, 0, 0, 0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: layer_done count %0d expected 1", done_cnt); end
    checks++; if (got_w.size() != OC*WW) begin errors++; $display("FAIL basic_wcount: got %0d expected %0d", got_w.size(), OC*WW); end
    checks++; if (got_f.size() != OC*NPIX) begin errors++; $display("FAIL basic_fcount: got %0d expected %0d", got_f.size(), OC*NPIX); end
    checks++; if (seq_mismatch() != 0) begin errors++; $display("FAIL basic_seq: %0d mismatches expected 0", seq_mismatch()); end
    for (int i = 0; i < 7 && i < got_f.size(); i++) begin
      checks++; if (got_f[i] !== 24'h0) begin errors++; $display("FAIL basic_pad%0d: got %h expected 0", i, got_f[i]); end
    end
    checks++;
    if (got_f.size() < 8 || got_f[7] !== fmem[0]) begin
      errors++; $display("FAIL basic_pix7: got %h expected %h", (got_f.size() > 7) ? got_f[7] : 24'hx, fmem[0]);
    end
    for (int i = 0; i < NPIX && i < got_f.size(); i++) if (got_f[i] == 24'h0) zeros++;
    checks++; if (zeros != 20) begin errors++; $display("FAIL basic_border: got %0d zeros expected 20", zeros); end
    checks++; if (frd_cnt != OC*IMG_W*IMG_H) begin errors++; $display("FAIL basic_frd: got %0d expected %0d", frd_cnt, OC*IMG_W*IMG_H); end
    checks++; if (wrd_cnt != OC*WW) begin errors++; $display("FAIL basic_wrd: got %0d expected %0d", wrd_cnt, OC*WW); end
    finish_layer();
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy %b expected 0", o_busy); end
  endtask

  task automatic test_random_ready();
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      fill_mem(); clear_mon();
      run_layer(1, 0, 0, 0, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: layer_done %0d expected 1", pass, done_cnt); end
      checks++;
      if (got_f.size() != OC*NPIX || got_w.size() != OC*WW) begin
        errors++; $display("FAIL rand%0d_count: pixels %0d words %0d expected %0d %0d", pass, got_f.size(), got_w.size(), OC*NPIX, OC*WW);
      end
      checks++; if (seq_mismatch() != 0) begin errors++; $display("FAIL rand%0d_seq: %0d mismatches expected 0", pass, seq_mismatch()); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL rand%0d_stable: %0d violations expected 0", pass, stab_err); end
      checks++; if (rd_idle_err != 0) begin errors++; $display("FAIL rand%0d_rd_idle: %0d expected 0", pass, rd_idle_err); end
      finish_layer();
    end
  endtask

  task automatic test_weight_stall();
    bit to;
    fill_mem(); clear_mon();
    run_layer(0, 1, 0, 0, to);
    checks++; if (to) begin errors++; $display("FAIL wstall_timeout: layer_done %0d expected 1", done_cnt); end
    checks++; if (stall_seen != 10) begin errors++; $display("FAIL wstall_len: held %0d cycles expected 10", stall_seen); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL wstall_stable: %0d violations expected 0", stab_err); end
    checks++; if (stall_rd != 0) begin errors++; $display("FAIL wstall_rd: %0d reads expected 0", stall_rd); end
    checks++; if (wrd_cnt != OC*WW) begin errors++; $display("FAIL wstall_wrd: got %0d expected %0d", wrd_cnt, OC*WW); end
    checks++; if (seq_mismatch() != 0 || got_w.size() != OC*WW) begin errors++; $display("FAIL wstall_seq: %0d mismatches, %0d words expected 0 %0d", seq_mismatch(), got_w.size(), OC*WW); end
    finish_layer();
  endtask

  task automatic test_once_done();
    bit to;
    fill_mem(); clear_mon();
    run_layer(0, 0, 1, 0, to);
    checks++; if (to) begin errors++; $display("FAIL once_timeout: layer_done %0d expected 1", done_cnt); end
    checks++;
    if (seq_mismatch() != 0 || got_f.size() != OC*NPIX) begin
      errors++; $display("FAIL once_seq: %0d mismatches, %0d pixels expected 0 %0d", seq_mismatch(), got_f.size(), OC*NPIX);
    end
    repeat (5) @(posedge s_clk);
    @(negedge s_clk);
    checks++;
    if (o_chnnl_idx !== 1'b1 || o_busy !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL once_done_hold: chnnl %0d busy %b done %0d expected 1 1 1", o_chnnl_idx, o_busy, done_cnt);
    end
    finish_layer();
    @(negedge s_clk);
    checks++;
    if (o_busy !== 1'b0 || o_chnnl_idx !== 1'b0) begin
      errors++; $display("FAIL once_release: busy %b chnnl %0d expected 0 0", o_busy, o_chnnl_idx);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    fill_mem(); clear_mon();
    run_layer(1, 0, 0, 1, to);
    checks++; if (to) begin errors++; $display("FAIL start_timeout: layer_done %0d expected 1", done_cnt); end
    checks++;
    if (got_f.size() != OC*NPIX || got_w.size() != OC*WW) begin
      errors++; $display("FAIL start_count: pixels %0d words %0d expected %0d %0d", got_f.size(), got_w.size(), OC*NPIX, OC*WW);
    end
    checks++; if (seq_mismatch() != 0) begin errors++; $display("FAIL start_seq: %0d mismatches expected 0", seq_mismatch()); end
    finish_layer();
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    checks++; if (done_cnt != 1 || o_busy !== 1'b0) begin errors++; $display("FAIL start_done: done %0d busy %b expected 1 0", done_cnt, o_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_weight_stall();
    test_once_done();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, errors %0d", errors);
    $fatal(1);
  end
endmodule
